// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, I-memory handshake and IF/ID register.
// Optional fetch-stall / flush performance counters are enabled by defining IF_PERF_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCEn,
  input  logic               IF_ID_En,
  input  logic               Branch_ID,
  input  logic [31:0]        BranchAddr_ID,
  input  logic               Jump_ID,
  input  logic [31:0]        JumpAddr_ID,
  output logic               IMemReq,
  output logic [IMEM_AW-1:0] IMemAddr,
  input  logic               IMemReady,
  input  logic [31:0]        IMemRdata,
  output logic [31:0]        Instr_ID,
  output logic [31:0]        PCPlus4_ID,
  output logic               Valid_ID
`ifdef IF_PERF_EN
  ,
  output logic [31:0]        PerfFetchStall,
  output logic [31:0]        PerfFlush
`endif
);

  typedef enum logic [1:0] {S_REQ, S_DROP, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        bubble;

  // A stalled ID stage cannot act on its own branch, so redirects need IF_ID_En.
  assign redirect = (Jump_ID | Branch_ID) & IF_ID_En;
  assign target   = Jump_ID ? {JumpAddr_ID[31:2], 2'b00} : {BranchAddr_ID[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  assign IMemReq    = (state_q == S_REQ) || (state_q == S_DROP);
  assign IMemAddr   = pc_q[IMEM_AW-1:0];
  assign Instr_ID   = instr_q;
  assign PCPlus4_ID = pc4_q;
  assign Valid_ID   = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_pc_d  = redir_pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    bubble      = 1'b0;

    case (state_q)
      S_REQ: begin
        if (IMemReady) begin
          if (redirect) begin
            pc_d   = target;
            bubble = 1'b1;
          end else if (IF_ID_En) begin
            instr_d = IMemRdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            if (PCEn) pc_d = pc_plus4;
          end else begin
            buf_instr_d = IMemRdata;
            buf_pc4_d   = pc_plus4;
            state_d     = S_HOLD;
          end
        end else if (redirect) begin
          redir_pc_d = target;
          bubble     = 1'b1;
          state_d    = S_DROP;
        end else if (IF_ID_En) begin
          bubble = 1'b1;
        end
      end
      S_DROP: begin
        // The request cannot be withdrawn: wait out the stale response, then jump.
        if (redirect) redir_pc_d = target;
        if (IF_ID_En) bubble = 1'b1;
        if (IMemReady) begin
          pc_d    = redirect ? target : redir_pc_q;
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          bubble  = 1'b1;
          state_d = S_REQ;
        end else if (IF_ID_En) begin
          instr_d = buf_instr_q;
          pc4_d   = buf_pc4_q;
          valid_d = 1'b1;
          if (PCEn) pc_d = pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (bubble) begin
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      redir_pc_q  <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_pc_q  <= redir_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

`ifdef IF_PERF_EN
  logic        fetch_stall;
  logic [31:0] perf_stall_q, perf_flush_q;

  // Redirect bubbles are flushes, not fetch stalls.
  assign fetch_stall = IF_ID_En & ~redirect &
                       (((state_q == S_REQ) & ~IMemReady) | (state_q == S_DROP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (fetch_stall && perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect && perf_flush_q != 32'hFFFF_FFFF) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign PerfFetchStall = perf_stall_q;
  assign PerfFlush      = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID words are queued when the memory returns them
// and popped when the decode register is expected to load.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        PCEn, IF_ID_En, Branch_ID, Jump_ID;
  logic [31:0] BranchAddr_ID, JumpAddr_ID;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemRdata;
  logic [31:0] Instr_ID, PCPlus4_ID;
  logic        Valid_ID;
`ifdef IF_PERF_EN
  logic [31:0] PerfFetchStall, PerfFlush;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic [64:0] last_q;

  if_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .PCEn(PCEn), .IF_ID_En(IF_ID_En),
    .Branch_ID(Branch_ID), .BranchAddr_ID(BranchAddr_ID),
    .Jump_ID(Jump_ID), .JumpAddr_ID(JumpAddr_ID),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemRdata(IMemRdata),
    .Instr_ID(Instr_ID), .PCPlus4_ID(PCPlus4_ID), .Valid_ID(Valid_ID)
`ifdef IF_PERF_EN
    , .PerfFetchStall(PerfFetchStall), .PerfFlush(PerfFlush)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick(input logic exp_req, input logic [31:0] exp_addr,
                      input logic rdy, input logic en, input logic pcen, input logic push,
                      input logic br = 1'b0, input logic [31:0] ba = 32'd0,
                      input logic jp = 1'b0, input logic [31:0] ja = 32'd0);
    logic [31:0] w;
    logic [63:0] e;
    logic        exp_valid;
    check("imem_req", {31'd0, IMemReq}, {31'd0, exp_req});
    check("imem_addr", IMemAddr, exp_addr);
    w             = mem_word(exp_addr);
    IMemReady     = rdy;
    IMemRdata     = rdy ? w : 32'hBAD0_BAD0;
    IF_ID_En      = en;
    PCEn          = pcen;
    Branch_ID     = br;
    BranchAddr_ID = ba;
    Jump_ID       = jp;
    JumpAddr_ID   = ja;
    if (push) sb.push_back({w, exp_addr + 32'd4});
    @(posedge clk);
    @(negedge clk);
    if (en) begin
      exp_valid = (sb.size() != 0);
      check("valid_id", {31'd0, Valid_ID}, {31'd0, exp_valid});
      if (exp_valid) begin
        e = sb.pop_front();
        check("instr_id", Instr_ID, e[63:32]);
        check("pcplus4_id", PCPlus4_ID, e[31:0]);
        last_q = {e, 1'b1};
      end else begin
        check("bubble_instr", Instr_ID, 32'd0);
        check("bubble_pc4", PCPlus4_ID, 32'd0);
        last_q = 65'd0;
      end
    end else begin
      check("hold_instr", Instr_ID, last_q[64:33]);
      check("hold_pc4", PCPlus4_ID, last_q[32:1]);
      check("hold_valid", {31'd0, Valid_ID}, {31'd0, last_q[0]});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    IMemReady = 1'b0; IMemRdata = 32'd0; PCEn = 1'b1; IF_ID_En = 1'b1;
    Branch_ID = 1'b0; BranchAddr_ID = 32'd0; Jump_ID = 1'b0; JumpAddr_ID = 32'd0;
    last_q = 65'd0;
    @(negedge clk);
    check("rst_valid", {31'd0, Valid_ID}, 32'd0);
    check("rst_instr", Instr_ID, 32'd0);
    check("rst_pc4", PCPlus4_ID, 32'd0);
    check("rst_req", {31'd0, IMemReq}, 32'd1);
    check("rst_addr", IMemAddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait sequential fetch
    tick(1, 32'h00, 1, 1, 1, 1);
    tick(1, 32'h04, 1, 1, 1, 1);
    tick(1, 32'h08, 1, 1, 1, 1);
    tick(1, 32'h0C, 1, 1, 1, 1);
    // Load-use stall while word at 0x10 returns
    tick(1, 32'h10, 1, 0, 0, 1);
    tick(0, 32'h10, 0, 1, 1, 0);
    tick(1, 32'h14, 1, 1, 1, 1);
    // Taken branch with zero-wait memory discards word at 0x18
    tick(1, 32'h18, 1, 1, 1, 0, 1'b1, 32'h40);
    tick(1, 32'h40, 1, 1, 1, 1);
    // Jump during a multi-cycle wait: address held, response dropped
    tick(1, 32'h44, 0, 1, 1, 0, 1'b0, 32'd0, 1'b1, 32'h103);
    tick(1, 32'h44, 0, 1, 1, 0);
    tick(1, 32'h44, 0, 1, 1, 0);
    tick(1, 32'h44, 1, 1, 1, 0);
    tick(1, 32'h100, 1, 1, 1, 1);
    tick(1, 32'h104, 0, 1, 1, 0);
    tick(1, 32'h104, 1, 1, 1, 1);
    // Jump beats branch
    tick(1, 32'h108, 1, 1, 1, 0, 1'b1, 32'h300, 1'b1, 32'h200);
    tick(1, 32'h200, 1, 1, 1, 1);
    // Branch while ID is stalled is ignored
    tick(1, 32'h204, 0, 0, 0, 0, 1'b1, 32'h300);
    tick(1, 32'h204, 1, 1, 1, 1);
    // Second redirect during a wait overwrites the first
    tick(1, 32'h208, 0, 1, 1, 0, 1'b1, 32'h400);
    tick(1, 32'h208, 0, 1, 1, 0, 1'b0, 32'd0, 1'b1, 32'h500);
    tick(1, 32'h208, 1, 1, 1, 0);
    tick(1, 32'h500, 1, 1, 1, 1);
    // PC wrap
    tick(1, 32'h504, 1, 1, 1, 0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    tick(1, 32'hFFFF_FFFC, 1, 1, 1, 1);
    tick(1, 32'h0, 1, 1, 1, 1);
    // Redirect while the held word is buffered drops it
    tick(1, 32'h4, 1, 0, 0, 0);
    tick(0, 32'h4, 0, 1, 1, 0, 1'b1, 32'h600);
    tick(1, 32'h600, 1, 1, 1, 1);
    tick(1, 32'h604, 0, 0, 0, 0);

    // Asynchronous reset between clock edges, mid-wait
    IMemReady = 1'b0; IF_ID_En = 1'b1; PCEn = 1'b1; Branch_ID = 1'b0; Jump_ID = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, Valid_ID}, 32'd0);
    check("arst_instr", Instr_ID, 32'd0);
    check("arst_pc4", PCPlus4_ID, 32'd0);
    check("arst_addr", IMemAddr, 32'd0);
    check("arst_req", {31'd0, IMemReq}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    last_q = 65'd0;
    tick(1, 32'h0, 1, 1, 1, 1);
    tick(1, 32'h4, 1, 1, 1, 1);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, I-memory request/response handshake and the IF/ID pipeline register.
- Consumes the stall enables (PCEn, IF_ID_En) from the hazard unit and the branch/jump redirects resolved in ID.
- Produces Instr_ID / PCPlus4_ID / Valid_ID for the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- IMEM_AW, 32, I-memory byte-address width. Upper PC bits beyond IMEM_AW are still kept in the PC.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCEn  in  1  hazard unit; 0 = hold PC.
- IF_ID_En  in  1  hazard unit; 0 = hold IF/ID register.
- Branch_ID  in  1  taken branch resolved in ID.
- BranchAddr_ID  in  32  branch target.
- Jump_ID  in  1  jump in ID.
- JumpAddr_ID  in  32  jump target.
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  IMEM_AW  fetch byte address, equal to PC[IMEM_AW-1:0].
- IMemReady  in  1  response valid this cycle; IMemRdata is valid.
- IMemRdata  in  32  fetched instruction word.
- Instr_ID  out  32  IF/ID instruction; 0 (NOP) when not valid.
- PCPlus4_ID  out  32  IF/ID PC+4.
- Valid_ID  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset values (async, rst_n low):
  - PC = RESET_PC, state = S_REQ.
  - Instr_ID = 0, PCPlus4_ID = 0, Valid_ID = 0.
  - Holding buffer empty, RedirPC = 0.
- Redirect = (Jump_ID | Branch_ID) & IF_ID_En.
  - Jump has priority over Branch.
  - Target bits [1:0] are forced to 0.
  - A redirect while IF_ID_En=0 is ignored; the branch is itself stalled in ID.
- Handshake:
  - IMemReq is high in S_REQ and S_DROP.
  - IMemAddr must stay stable while IMemReq=1 and IMemReady=0. A request is never withdrawn.
  - Response latency is one or more cycles; a same-cycle IMemReady with IMemReq is legal.
- FSM:
  - S_REQ:
    - IMemReady=1 & Redirect: discard word, PC <= target, IF/ID <= bubble, stay.
    - IMemReady=1 & IF_ID_En: IF/ID <= {IMemRdata, PC+4, 1}. PC <= PC+4 if PCEn, else held.
    - IMemReady=1 & !IF_ID_En: buffer <= {IMemRdata, PC+4}, PC held, go S_HOLD.
    - IMemReady=0 & Redirect: RedirPC <= target, IF/ID <= bubble, go S_DROP.
    - IMemReady=0 & IF_ID_En: IF/ID <= bubble.
    - IMemReady=0 & !IF_ID_En: IF/ID held.
  - S_DROP:
    - IMemReq stays high at the old address.
    - Redirect here overwrites RedirPC; IF/ID <= bubble when IF_ID_En.
    - On IMemReady: discard word, PC <= RedirPC (or the new target if Redirect in the same cycle), go S_REQ.
  - S_HOLD:
    - IMemReq = 0.
    - Redirect: drop buffer, PC <= target, IF/ID <= bubble, go S_REQ.
    - Else if IF_ID_En: IF/ID <= {buffer, 1}, PC <= PC+4 if PCEn, go S_REQ.
    - Else hold.
- Bubble = {Instr_ID=0, PCPlus4_ID=0, Valid_ID=0}.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no exception is raised.
- Reset mid-request: state returns to S_REQ immediately; the outstanding memory response is the memory's responsibility. The first post-reset request is to RESET_PC.

Optional Feature:
- Macro: IF_PERF_EN.
- When defined, adds:
  - Output PerfFetchStall[31:0]: counts cycles with IF_ID_En=1 and a bubble inserted for lack of a word.
  - Output PerfFlush[31:0]: counts Redirect cycles.
  - Both counters reset to 0, saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Zero-wait fetch: RESET_PC=0, IMemReady tied 1, IMemRdata=addr-derived, enables=1 -> IMemAddr 0,4,8,...; Valid_ID=1 from cycle 2; PCPlus4_ID 4,8,12.
- Load-use stall: IF_ID_En=PCEn=0 for 1 cycle while word at 0x10 returns -> S_HOLD, IMemReq=0; next cycle Instr_ID=word@0x10, PCPlus4_ID=0x14, next IMemAddr=0x14; no instruction lost or duplicated.
- Branch with zero-wait memory: Branch_ID=1, BranchAddr_ID=0x40 at PC=0x18 -> Valid_ID=0 next cycle, next IMemAddr=0x40, word@0x18 discarded.
- Redirect during 3-cycle memory wait: Jump_ID=1, JumpAddr_ID=0x103 -> IMemAddr held until IMemReady, response dropped, then IMemAddr=0x100.
- Jump+Branch simultaneous (0x200 / 0x300) -> next fetch 0x200. Stalled branch (IF_ID_En=0) -> ignored.
- Wrap and reset: PC=0xFFFF_FFFC fetch -> next address 0; rst_n low mid-wait -> all outputs at reset values asynchronously, next request 0x0.
